line_sum_seq: RTL and testbench

LINE_SUM_SEQ -- requirements
Module: line_sum_seq

---
 rtl/line_sum_pkg.sv | 22 ++
 rtl/line_sum_seq_if.sv | 37 +++
 rtl/line_sum_dp.sv | 60 ++++++
 rtl/line_sum_seq.sv | 175 +++++++++++++++++
 tb/tb_line_sum_seq.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_sum_pkg.sv
// Shared types and widths for the three-row line-sum block.
package line_sum_pkg;

  localparam int PIX_W = 8;
  localparam int SUM_W = 10;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    FILL1 = 2'd0,
    FILL2 = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  // Three-pixel column sum; 3 x 255 = 765 always fits in SUM_W bits.
  function automatic logic [SUM_W-1:0] sum3(input logic [PIX_W-1:0] a,
                                            input logic [PIX_W-1:0] b,
                                            input logic [PIX_W-1:0] c);
    return SUM_W'(a) + SUM_W'(b) + SUM_W'(c);
  endfunction

endpackage

// File: rtl/line_sum_seq_if.sv
// Pixel input, line-FIFO and result-stream signals of line_sum_seq.
interface line_sum_seq_if;
  import line_sum_pkg::*;

  logic             restart;
  logic [PIX_W-1:0] pix_data;
  logic             pix_valid;
  logic             fifo1_wr;
  logic             fifo2_wr;
  logic [PIX_W-1:0] fifo1_din;
  logic [PIX_W-1:0] fifo2_din;
  logic             fifo1_rd;
  logic             fifo2_rd;
  logic [PIX_W-1:0] fifo1_dout;
  logic [PIX_W-1:0] fifo2_dout;
  logic             fifo_sclr;
  logic [SUM_W-1:0] sum_data;
  logic             sum_valid;
  logic             sum_ready;
  logic             frame_done;
  logic             ovf_err;

  // The line-sum block itself.
  modport master (
    input  restart, pix_data, pix_valid, fifo1_dout, fifo2_dout, sum_ready,
    output fifo1_wr, fifo2_wr, fifo1_din, fifo2_din, fifo1_rd, fifo2_rd,
           fifo_sclr, sum_data, sum_valid, frame_done, ovf_err
  );

  // The environment: pixel source, line FIFOs and result sink.
  modport slave (
    output restart, pix_data, pix_valid, fifo1_dout, fifo2_dout, sum_ready,
    input  fifo1_wr, fifo2_wr, fifo1_din, fifo2_din, fifo1_rd, fifo2_rd,
           fifo_sclr, sum_data, sum_valid, frame_done, ovf_err
  );

endinterface

// File: rtl/line_sum_dp.sv
// Datapath: pixel and FIFO-output capture, three-input adder and the
// result register that holds its value until the consumer accepts it.
module line_sum_dp
  import line_sum_pkg::*;
(
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             ld_pix,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             ld_dout,
  input  logic [PIX_W-1:0] fifo1_dout,
  input  logic [PIX_W-1:0] fifo2_dout,
  input  logic             ld_sum,
  input  logic             sum_ready,
  output logic [PIX_W-1:0] pix_q,
  output logic [SUM_W-1:0] sum_data,
  output logic             sum_valid
);

  logic [PIX_W-1:0] f1_q;
  logic [PIX_W-1:0] f2_q;

  // Capture the accepted pixel and the two older rows read back from the FIFOs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      pix_q <= '0;
      f1_q  <= '0;
      f2_q  <= '0;
    end else if (clear) begin
      pix_q <= '0;
      f1_q  <= '0;
      f2_q  <= '0;
    end else begin
      if (ld_pix) pix_q <= pix_data;
      if (ld_dout) begin
        f1_q <= fifo1_dout;
        f2_q <= fifo2_dout;
      end
    end
  end

  // Result register: load a new sum, otherwise hold until transferred.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_valid <= 1'b0;
      sum_data  <= '0;
    end else if (clear) begin
      sum_valid <= 1'b0;
      sum_data  <= '0;
    end else if (ld_sum) begin
      sum_valid <= 1'b1;
      sum_data  <= sum3(f1_q, f2_q, pix_q);
    end else if (sum_valid && sum_ready) begin
      sum_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/line_sum_seq.sv
// Three-row column summer: sequences two external line FIFOs so that each
// pixel from the third row on is added to the pixels directly above it.
module line_sum_seq
  import line_sum_pkg::*;
#(
  parameter int COL = 5,
  parameter int ROW = 5
) (
  input logic            sys_clk,
  input logic            rst_n,
  line_sum_seq_if.master bus
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COL - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROW - 1);
  localparam logic [CNT_W-1:0] COL_NUM  = CNT_W'(COL);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] fl_q, fl_d;      // FLUSH reads issued so far
  logic [2:0]       pipe_q;          // bit i set: accepted pixel is in cycle T+1+i
  logic             busy, accept, drop, col_last, s2_run, s3_run, stalled;
  logic             wr1_d, wr2_d, rd_d, done_d;
  logic [PIX_W-1:0] din1_d, din2_d;
  logic [PIX_W-1:0] pix_q;

  assign stalled  = bus.sum_valid && !bus.sum_ready;
  assign busy     = (|pipe_q) || stalled;
  assign accept   = bus.pix_valid && !bus.restart && (state_q != FLUSH) && !busy;
  assign drop     = bus.pix_valid && !bus.restart && !accept;
  assign col_last = (col_q == COL_LAST);
  assign s2_run   = pipe_q[1] && (state_q == RUN);
  assign s3_run   = pipe_q[2] && (state_q == RUN);

  // State register; restart returns to FILL1 from any state.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)           state_q <= FILL1;
    else if (bus.restart) state_q <= FILL1;
    else                  state_q <= state_d;
  end

  // Next state, counters and next values of the registered FIFO strobes.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    fl_d    = fl_q;
    wr1_d   = 1'b0;
    wr2_d   = 1'b0;
    rd_d    = 1'b0;
    done_d  = 1'b0;
    din1_d  = bus.fifo1_din;
    din2_d  = bus.fifo2_din;

    // Stage 1: fill writes go out directly, RUN reads both older rows.
    if (accept) begin
      unique case (state_q)
        FILL1:   begin wr1_d = 1'b1; din1_d = bus.pix_data; end
        FILL2:   begin wr2_d = 1'b1; din2_d = bus.pix_data; end
        RUN:     rd_d = 1'b1;
        default: ;
      endcase
    end

    // Stage 2 in RUN: shift rows down one FIFO (row n-1 -> FIFO1, row n -> FIFO2).
    if (s2_run) begin
      wr1_d  = 1'b1;
      wr2_d  = 1'b1;
      din1_d = bus.fifo2_dout;
      din2_d = pix_q;
    end

    // Stage 3 retires the pixel; position and state advance only here, so
    // the state seen by stages 1-2 is the one the pixel was accepted in.
    if (pipe_q[2]) begin
      col_d = col_last ? '0 : col_q + 1'b1;
      if (col_last) begin
        unique case (state_q)
          FILL1: begin state_d = FILL2; row_d = CNT_W'(1); end
          FILL2: begin state_d = RUN;   row_d = CNT_W'(2); end
          RUN: begin
            if (row_q == ROW_LAST) begin
              state_d = FLUSH;
              rd_d    = 1'b1;
              fl_d    = CNT_W'(1);
            end else begin
              row_d = row_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    // Drain COL entries from each FIFO, then wait for the last result.
    if (state_q == FLUSH) begin
      if (fl_q != COL_NUM) begin
        rd_d = 1'b1;
        fl_d = fl_q + 1'b1;
      end else if (!stalled) begin
        done_d  = 1'b1;
        state_d = FILL1;
        col_d   = '0;
        row_d   = '0;
        fl_d    = '0;
      end
    end
  end

  // Counters, pipeline tags and registered FIFO/status outputs.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q          <= '0;
      row_q          <= '0;
      fl_q           <= '0;
      pipe_q         <= '0;
      bus.fifo1_wr   <= 1'b0;
      bus.fifo2_wr   <= 1'b0;
      bus.fifo1_rd   <= 1'b0;
      bus.fifo2_rd   <= 1'b0;
      bus.fifo1_din  <= '0;
      bus.fifo2_din  <= '0;
      bus.frame_done <= 1'b0;
      bus.ovf_err    <= 1'b0;
      bus.fifo_sclr  <= 1'b1;
    end else if (bus.restart) begin
      col_q          <= '0;
      row_q          <= '0;
      fl_q           <= '0;
      pipe_q         <= '0;
      bus.fifo1_wr   <= 1'b0;
      bus.fifo2_wr   <= 1'b0;
      bus.fifo1_rd   <= 1'b0;
      bus.fifo2_rd   <= 1'b0;
      bus.fifo1_din  <= '0;
      bus.fifo2_din  <= '0;
      bus.frame_done <= 1'b0;
      bus.ovf_err    <= 1'b0;
      bus.fifo_sclr  <= 1'b1;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      fl_q           <= fl_d;
      pipe_q         <= {pipe_q[1:0], accept};
      bus.fifo1_wr   <= wr1_d;
      bus.fifo2_wr   <= wr2_d;
      bus.fifo1_rd   <= rd_d;
      bus.fifo2_rd   <= rd_d;
      bus.fifo1_din  <= din1_d;
      bus.fifo2_din  <= din2_d;
      bus.frame_done <= done_d;
      bus.ovf_err    <= bus.ovf_err | drop;
      bus.fifo_sclr  <= 1'b0;
    end
  end

  line_sum_dp u_dp (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .clear      (bus.restart),
    .ld_pix     (accept),
    .pix_data   (bus.pix_data),
    .ld_dout    (s2_run),
    .fifo1_dout (bus.fifo1_dout),
    .fifo2_dout (bus.fifo2_dout),
    .ld_sum     (s3_run),
    .sum_ready  (bus.sum_ready),
    .pix_q      (pix_q),
    .sum_data   (bus.sum_data),
    .sum_valid  (bus.sum_valid)
  );

endmodule

// File: tb/tb_line_sum_seq.sv
// Bench for line_sum_seq: behavioural line FIFOs, a frame-level sum model
// and a per-cycle compare process, driven by directed frames.
module tb_line_sum_seq;

  localparam int COL = 5;
  localparam int ROW = 5;

  logic sys_clk;
  logic rst_n;
  line_sum_seq_if bus ();

  line_sum_seq #(.COL(COL), .ROW(ROW)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Line FIFOs: read data appears the cycle after the read request.
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int underflows = 0;
  always @(posedge sys_clk) begin
    if (bus.fifo_sclr) begin
      q1.delete();
      q2.delete();
    end else begin
      if (bus.fifo1_rd) begin
        if (q1.size() > 0) bus.fifo1_dout <= q1.pop_front();
        else underflows++;
      end
      if (bus.fifo2_rd) begin
        if (q2.size() > 0) bus.fifo2_dout <= q2.pop_front();
        else underflows++;
      end
      if (bus.fifo1_wr) q1.push_back(bus.fifo1_din);
      if (bus.fifo2_wr) q2.push_back(bus.fifo2_din);
    end
  end

  // Frame model: each accepted pixel from row 2 on yields the sum of itself
  // and the accepted pixels one and two rows above it in the same column.
  logic [7:0] frame_px[$];
  int exp_q[$];
  int got[$];
  bit exp_ovf = 1'b0;
  int frames_seen = 0;

  task automatic model_accept(input logic [7:0] v);
    int i;
    frame_px.push_back(v);
    i = frame_px.size() - 1;
    if (i >= 2 * COL)
      exp_q.push_back(int'(frame_px[i]) + int'(frame_px[i - COL]) + int'(frame_px[i - 2 * COL]));
    if (frame_px.size() == ROW * COL) frame_px.delete();
  endtask

  task automatic model_clear();
    frame_px.delete();
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  // Compare process: sampled on the falling edge, away from the active edge.
  bit         prev_stall = 1'b0;
  logic [9:0] prev_data  = '0;
  always @(negedge sys_clk) begin
    if (rst_n) begin
      check("ovf_err", 32'(bus.ovf_err), 32'(exp_ovf));
      if (bus.fifo1_rd || bus.fifo1_wr) check("fifo1_rd_wr_same_cycle", 32'(bus.fifo1_rd & bus.fifo1_wr), 0);
      if (bus.fifo2_rd || bus.fifo2_wr) check("fifo2_rd_wr_same_cycle", 32'(bus.fifo2_rd & bus.fifo2_wr), 0);
      if (prev_stall) begin
        check("sum_valid_hold", 32'(bus.sum_valid), 1);
        check("sum_data_hold", 32'(bus.sum_data), 32'(prev_data));
      end
      if (bus.sum_valid && bus.sum_ready) begin
        check("sum_expected_present", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("sum_data", 32'(bus.sum_data), 32'(exp_q.pop_front()));
        got.push_back(int'(bus.sum_data));
      end
      if (bus.frame_done) frames_seen++;
      prev_stall = bus.sum_valid && !bus.sum_ready;
      prev_data  = bus.sum_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Stimulus runs in phase posedge+1.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] v, input bit acc);
    bus.pix_data  = v;
    bus.pix_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    bus.pix_valid = 1'b0;
    if (acc) model_accept(v);
    else exp_ovf = 1'b1;
  endtask

  task automatic do_restart(input bit with_pix);
    bus.restart = 1'b1;
    if (with_pix) begin
      bus.pix_data  = 8'd55;
      bus.pix_valid = 1'b1;
    end
    @(posedge sys_clk);
    #1;
    bus.restart   = 1'b0;
    bus.pix_valid = 1'b0;
    model_clear();
    check("restart_fifo_sclr_high", 32'(bus.fifo_sclr), 1);
    check("restart_ovf_clear", 32'(bus.ovf_err), 0);
    check("restart_sum_valid_clear", 32'(bus.sum_valid), 0);
    idle(1);
    check("restart_fifo_sclr_one_cycle", 32'(bus.fifo_sclr), 0);
    check("restart_fifo1_empty", 32'(q1.size()), 0);
    check("restart_fifo2_empty", 32'(q2.size()), 0);
  endtask

  // Modes: 0 rows k, 1 all 255, 2 drop in RUN, 3 stall in RUN,
  // 4 restart in row 3, 5 stop mid-FLUSH.
  task automatic frame(input int mode);
    logic [7:0] v;
    got.delete();
    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        v = (mode == 1) ? 8'hFF : 8'(r + 1);
        send(v, 1'b1);
        if (mode == 2 && r == 2 && c == 1) begin
          idle(1);
          send(8'd99, 1'b0);
          idle(9);
          check("drop_fifo1_level", 32'(q1.size()), COL);
          check("drop_fifo2_level", 32'(q2.size()), COL);
        end else if (mode == 3 && r == 3 && c == 2) begin
          bus.sum_ready = 1'b0;
          idle(10);
          check("stall_sum_valid", 32'(bus.sum_valid), 1);
          check("stall_sum_data", 32'(bus.sum_data), 9);
          send(8'd77, 1'b0);
          idle(9);
          bus.sum_ready = 1'b1;
          idle(11);
        end else if (mode == 4 && r == 2 && c == 1) begin
          idle(1);
          do_restart(1'b1);
          return;
        end else if (mode == 5 && r == ROW - 1 && c == COL - 1) begin
          idle(6);
          return;
        end else begin
          idle(11);
        end
      end
    end
    idle(15);
  endtask

  task automatic check_rows_frame(input string tag, input int f0);
    check({tag, "_count"}, 32'(got.size()), 15);
    check({tag, "_first"}, 32'(got[0]), 6);
    check({tag, "_row4"}, 32'(got[5]), 9);
    check({tag, "_last"}, 32'(got[14]), 12);
    check({tag, "_frame_done"}, 32'(frames_seen - f0), 1);
    check({tag, "_fifo1_empty"}, 32'(q1.size()), 0);
    check({tag, "_fifo2_empty"}, 32'(q2.size()), 0);
    check({tag, "_all_delivered"}, 32'(exp_q.size()), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"},
          32'({bus.fifo1_wr, bus.fifo2_wr, bus.fifo1_rd, bus.fifo2_rd,
               bus.sum_valid, bus.frame_done, bus.ovf_err, bus.fifo_sclr}), 32'h01);
    check({tag, "_data"}, 32'({bus.fifo1_din, bus.fifo2_din, bus.sum_data}), 0);
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    #1;
    check("rst_release_sclr_held", 32'(bus.fifo_sclr), 1);
    idle(1);
    check("rst_release_sclr_dropped", 32'(bus.fifo_sclr), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    rst_n         = 1'b1;
    bus.restart   = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.sum_ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_reset_outputs("por");
    @(posedge sys_clk);
    #1;
    release_reset();

    // Rows of constant value k: 6 / 9 / 12 per row.
    f0 = frames_seen;
    frame(0);
    check_rows_frame("basic", f0);
    check("basic_ovf", 32'(bus.ovf_err), 0);

    // Saturated pixels: 765 with no wrap.
    frame(1);
    check("max_count", 32'(got.size()), 15);
    foreach (got[i]) check("max_sum", 32'(got[i]), 32'h2FD);

    // Pixel arriving while the RUN pipeline is busy is dropped.
    f0 = frames_seen;
    frame(2);
    check_rows_frame("drop", f0);
    check("drop_ovf_sticky", 32'(bus.ovf_err), 1);

    // Output stall with a pixel arriving mid-stall.
    do_restart(1'b0);
    f0 = frames_seen;
    frame(3);
    check_rows_frame("stall", f0);
    check("stall_held_result", 32'(got[7]), 9);
    check("stall_ovf_sticky", 32'(bus.ovf_err), 1);

    // Restart in row 3 together with a pixel, then a clean frame.
    frame(4);
    f0 = frames_seen;
    frame(0);
    check_rows_frame("after_restart", f0);
    check("after_restart_ovf", 32'(bus.ovf_err), 0);

    // Reset pulsed mid-FLUSH, then a clean frame.
    f0 = frames_seen;
    frame(5);
    rst_n = 1'b0;
    model_clear();
    #1;
    check_reset_outputs("midflush_rst");
    check("midflush_no_frame_done", 32'(frames_seen - f0), 0);
    idle(2);
    release_reset();
    f0 = frames_seen;
    frame(0);
    check_rows_frame("after_rst", f0);

    check("fifo_underflows", 32'(underflows), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
